// File: rtl/queen_search_ctrl.sv
// Backtracking sequencer for an N-queens solver: steers external row/column
// counters and a column stack, and walks placements in lexicographic order.
module queen_search_ctrl #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         next,
    input  logic         conflict,
    input  logic [W-1:0] row_value,
    input  logic         row_zero,
    input  logic [W-1:0] col_value,
    input  logic [W-1:0] stack_col,
    output logic         row_reset,
    output logic         row_up,
    output logic         row_down,
    output logic         col_reset,
    output logic         col_load,
    output logic         col_up,
    output logic [W-1:0] col_data,
    output logic         stack_we,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         no_solution
);

    typedef enum logic [2:0] {
        IDLE, INIT, CHECK, PLACE, BACKTRACK, POP, SOLVED, FAIL
    } state_t;

    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t state, nxt;

    // Strobes are gated by reset so an abandoned search never touches the counters.
    always_comb begin
        nxt       = state;
        row_reset = 1'b0;
        row_up    = 1'b0;
        row_down  = 1'b0;
        col_reset = 1'b0;
        col_load  = 1'b0;
        col_up    = 1'b0;
        col_data  = '0;
        stack_we  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (start) nxt = INIT;
                INIT: begin
                    row_reset = 1'b1;
                    col_reset = 1'b1;
                    nxt       = CHECK;
                end
                CHECK: begin
                    if (!conflict)
                        nxt = PLACE;
                    else if (col_value != LAST)
                        col_up = 1'b1;
                    else
                        nxt = BACKTRACK;
                end
                PLACE: begin
                    stack_we = 1'b1;
                    if (row_value == LAST) begin
                        nxt = SOLVED;
                    end else begin
                        row_up    = 1'b1;
                        col_reset = 1'b1;
                        nxt       = CHECK;
                    end
                end
                BACKTRACK: begin
                    if (row_zero) begin
                        nxt = FAIL;
                    end else begin
                        row_down = 1'b1;
                        nxt      = POP;
                    end
                end
                POP: begin
                    // stack_col already reflects the decremented row
                    col_data = stack_col + W'(1);
                    if (stack_col == LAST) begin
                        nxt = BACKTRACK;
                    end else begin
                        col_load = 1'b1;
                        nxt      = CHECK;
                    end
                end
                SOLVED: begin
                    if (start) begin
                        nxt = INIT;
                    end else if (next) begin
                        if (col_value != LAST) begin
                            col_up = 1'b1;
                            nxt    = CHECK;
                        end else begin
                            nxt = BACKTRACK;
                        end
                    end
                end
                FAIL: if (start) nxt = INIT;
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            no_solution <= 1'b0;
        end else begin
            state       <= nxt;
            busy        <= (nxt == INIT) || (nxt == CHECK) || (nxt == PLACE) ||
                           (nxt == BACKTRACK) || (nxt == POP);
            done        <= ((nxt == SOLVED) && (state != SOLVED)) ||
                           ((nxt == FAIL) && (state != FAIL));
            found       <= (nxt == SOLVED);
            no_solution <= (nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_queen_search_ctrl.sv
// Bench for queen_search_ctrl: four board sizes, each with its own counters,
// stack and attack checker, compared against a permutation-based solution list.
module tb_queen_search_ctrl;

    typedef int board_t [8];
    typedef struct {
        int     cfg;
        int     nsol;
        int     idx;
        board_t sol;
    } vec_t;

    logic clk;
    logic reset;
    logic [3:0] start_v, next_v, done_v, found_v, nosol_v, busy_v;
    logic [3:0][7:0] strb_v;
    logic [3:0][7:0][2:0] stk_v;

    int checks;
    int errors;
    board_t msol[$];
    board_t seen[$];
    vec_t tv [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int NN = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 1 : 3;
        localparam int WW = (g == 0) ? 3 : (g == 2) ? 1 : 2;
        logic [WW-1:0] row, col, col_data, stack_col;
        logic [WW-1:0] mem [8];
        logic conflict, row_zero, row_reset, row_up, row_down;
        logic col_reset, col_load, col_up, stack_we, busy, done, found, no_solution;

        assign row_zero  = (row == '0);
        assign stack_col = mem[row];

        always_comb begin
            conflict = 1'b0;
            for (int r = 0; r < 8; r++)
                if (r < int'(row) &&
                    (mem[r] == col ||
                     int'(mem[r]) - int'(col) == int'(row) - r ||
                     int'(col) - int'(mem[r]) == int'(row) - r))
                    conflict = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                row <= '0;
                col <= '0;
            end else begin
                if (row_reset)     row <= '0;
                else if (row_up)   row <= row + 1'b1;
                else if (row_down) row <= row - 1'b1;
                if (col_reset)     col <= '0;
                else if (col_load) col <= col_data;
                else if (col_up)   col <= col + 1'b1;
                if (stack_we)      mem[row] <= col;
            end
        end

        queen_search_ctrl #(.N(NN), .W(WW)) dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .next(next_v[g]),
            .conflict(conflict), .row_value(row), .row_zero(row_zero),
            .col_value(col), .stack_col(stack_col),
            .row_reset(row_reset), .row_up(row_up), .row_down(row_down),
            .col_reset(col_reset), .col_load(col_load), .col_up(col_up),
            .col_data(col_data), .stack_we(stack_we), .busy(busy), .done(done),
            .found(found), .no_solution(no_solution)
        );

        assign busy_v[g]  = busy;
        assign done_v[g]  = done;
        assign found_v[g] = found;
        assign nosol_v[g] = no_solution;
        assign strb_v[g]  = {|col_data, stack_we, col_up, col_load, col_reset,
                             row_down, row_up, row_reset};
        for (genvar k = 0; k < 8; k++) begin : stk
            assign stk_v[g][k] = 3'(mem[k]);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Solutions are permutations, so lexicographic permutation order gives
    // lexicographic solution order directly.
    task automatic model(input int n);
        int p[8];
        int i, j, t;
        bit ok;
        board_t b;
        msol.delete();
        for (int k = 0; k < 8; k++) p[k] = (k < n) ? k : 0;
        while (1) begin
            ok = 1'b1;
            for (int a = 0; a < n; a++)
                for (int c = a + 1; c < n; c++)
                    if (p[a] - p[c] == c - a || p[c] - p[a] == c - a) ok = 1'b0;
            if (ok) begin
                for (int k = 0; k < 8; k++) b[k] = p[k];
                msol.push_back(b);
            end
            i = n - 2;
            while (i >= 0 && p[i] >= p[i+1]) i--;
            if (i < 0) break;
            j = n - 1;
            while (p[j] <= p[i]) j--;
            t = p[i]; p[i] = p[j]; p[j] = t;
            for (int a = i + 1, c = n - 1; a < c; a++, c--) begin
                t = p[a]; p[a] = p[c]; p[c] = t;
            end
        end
    endtask

    task automatic pulse_start(input int c);
        start_v[c] = 1'b1;
        @(negedge clk);
        start_v[c] = 1'b0;
    endtask

    task automatic pulse_next(input int c);
        next_v[c] = 1'b1;
        @(negedge clk);
        next_v[c] = 1'b0;
    endtask

    // kind: 1 = found, 2 = no_solution, 0 = timed out
    task automatic wait_event(input int c, input bit noise, output int kind,
                              output int cyc, output int dn);
        kind = 0; cyc = 0; dn = 0;
        while (kind == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done_v[c]) dn++;
            if (found_v[c]) kind = 1;
            else if (nosol_v[c]) kind = 2;
            if (kind == 0 && noise) begin
                start_v[c] = ($urandom_range(0, 3) == 0);
                next_v[c]  = ($urandom_range(0, 3) == 0);
            end else begin
                start_v[c] = 1'b0;
                next_v[c]  = 1'b0;
            end
        end
        start_v[c] = 1'b0;
        next_v[c]  = 1'b0;
        if (kind == 0) chk("event_timeout", cyc, -1);
    endtask

    task automatic grab(input int c, output board_t b);
        for (int k = 0; k < 8; k++) b[k] = int'(stk_v[c][k]);
    endtask

    task automatic run_all(input int c, input int n, input bit noise);
        int kind, cyc, dn, idx;
        board_t b;
        model(n);
        seen.delete();
        idx = 0;
        pulse_start(c);
        chk("busy_after_start", busy_v[c], 1);
        chk("found_after_start", found_v[c], 0);
        chk("nosol_after_start", nosol_v[c], 0);
        for (int e = 0; e < 200; e++) begin
            wait_event(c, noise, kind, cyc, dn);
            if (kind == 0) break;
            chk("done_pulses", dn, 1);
            chk("busy_at_event", busy_v[c], 0);
            if (kind == 2) begin
                chk("solution_count", idx, msol.size());
                chk("found_in_fail", found_v[c], 0);
                break;
            end
            grab(c, b);
            seen.push_back(b);
            if (idx < msol.size())
                for (int k = 0; k < n; k++) chk($sformatf("sol%0d_n%0d_col%0d", idx, n, k), b[k], msol[idx][k]);
            else
                chk("extra_solution", idx, msol.size() - 1);
            idx++;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            chk("done_held_low", done_v[c], 0);
            chk("found_held", found_v[c], 1);
            pulse_next(c);
        end
        for (int v = 0; v < 5; v++)
            if (tv[v].cfg == c) begin
                chk("table_count", seen.size(), tv[v].nsol);
                if (tv[v].idx >= 0) begin
                    if (tv[v].idx < seen.size())
                        for (int k = 0; k < n; k++)
                            chk($sformatf("table%0d_col%0d", v, k), seen[tv[v].idx][k], tv[v].sol[k]);
                    else
                        chk("table_missing", seen.size(), tv[v].idx + 1);
                end
            end
    endtask

    initial begin
        int kind, cyc0, cyc1, dn, w;
        board_t b0, b1;
        checks = 0; errors = 0;
        start_v = '0; next_v = '0;
        reset = 1'b1;
        tv[0] = '{cfg: 0, nsol: 92, idx: 0,  sol: '{0,4,7,5,2,6,1,3}};
        tv[1] = '{cfg: 0, nsol: 92, idx: 91, sol: '{7,3,0,2,5,1,6,4}};
        tv[2] = '{cfg: 1, nsol: 2,  idx: 0,  sol: '{1,3,0,2,0,0,0,0}};
        tv[3] = '{cfg: 1, nsol: 2,  idx: 1,  sol: '{2,0,3,1,0,0,0,0}};
        tv[4] = '{cfg: 3, nsol: 0,  idx: -1, sol: '{0,0,0,0,0,0,0,0}};
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chk("rst_busy", busy_v[c], 0);
            chk("rst_flags", {done_v[c], found_v[c], nosol_v[c]}, 0);
            chk("rst_strobes", strb_v[c], 0);
        end

        // N=1 exact timing: start sampled at e0, SOLVED entered at e3
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        chk("n1_e0_busy", busy_v[2], 1);
        chk("n1_e0_done", done_v[2], 0);
        @(negedge clk);
        @(negedge clk);
        chk("n1_e2_done", done_v[2], 0);
        chk("n1_e2_busy", busy_v[2], 1);
        @(negedge clk);
        chk("n1_e3_done", done_v[2], 1);
        chk("n1_e3_found", found_v[2], 1);
        chk("n1_e3_busy", busy_v[2], 0);
        chk("n1_e3_stack", stk_v[2][0], 0);
        @(negedge clk);
        chk("n1_e4_done", done_v[2], 0);
        chk("n1_e4_found", found_v[2], 1);

        // N=8 first solution, clean and with start/next noise while busy
        pulse_start(0);
        wait_event(0, 1'b0, kind, cyc0, dn);
        chk("n8_first_kind", kind, 1);
        chk("n8_first_done", dn, 1);
        chk("n8_first_busy", busy_v[0], 0);
        grab(0, b0);
        for (int k = 0; k < 8; k++) chk("n8_first_col", b0[k], tv[0].sol[k]);
        @(negedge clk);
        chk("n8_done_once", done_v[0], 0);
        pulse_start(0);
        wait_event(0, 1'b1, kind, cyc1, dn);
        chk("noisy_kind", kind, 1);
        chk("noisy_cycles", cyc1, cyc0);
        grab(0, b1);
        for (int k = 0; k < 8; k++) chk("noisy_col", b1[k], b0[k]);

        // Reset while CHECK is stepping the column
        pulse_start(0);
        w = 0;
        while (!strb_v[0][5] && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("saw_col_up", strb_v[0][5], 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_strobes", strb_v[0], 0);
        @(negedge clk);
        chk("rst_mid_busy", busy_v[0], 0);
        chk("rst_mid_flags", {done_v[0], found_v[0], nosol_v[0]}, 0);
        chk("rst_mid_strobes_after", strb_v[0], 0);
        reset = 1'b0;
        @(negedge clk);

        run_all(1, 4, 1'b1);
        run_all(2, 1, 1'b1);
        run_all(3, 3, 1'b1);
        run_all(3, 3, 1'b0);
        run_all(0, 8, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/queen_search_ctrl.md
Name: queen_search_ctrl

Overview:
- Backtracking sequencer for the N-queens solver.
- Drives the control strobes of two external up/down counters (row, column) and one column-stack RAM. Consumes the counter status and a combinational conflict flag from the board checker.
- Enumerates placements in lexicographic order. Reports each solution and supports continued search for the next solution.

Parameters:
N, 8, board size; legal range 1..2^W.
W, 3, index width of the row/column counters and stack entries.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin new search; sampled in IDLE, SOLVED, FAIL
next  in  1  resume search for next solution; sampled in SOLVED only
conflict  in  1  checker: queen at (row_value,col_value) attacks rows 0..row_value-1; must be 0 when row_value=0
row_value  in  W  row counter value
row_zero  in  1  row counter is zero
col_value  in  W  column counter value
stack_col  in  W  combinational read of stack[row_value]
row_reset  out  1  clear row counter
row_up  out  1  increment row counter
row_down  out  1  decrement row counter
col_reset  out  1  clear column counter
col_load  out  1  load column counter with col_data
col_up  out  1  increment column counter
col_data  out  W  column load value
stack_we  out  1  write col_value into stack[row_value]
busy  out  1  search in progress
done  out  1  one-cycle pulse on entering SOLVED or FAIL
found  out  1  level: stack holds a valid solution
no_solution  out  1  level: search space exhausted

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk. On reset the FSM goes to IDLE. All strobes, busy, done, found and no_solution are 0. Reset mid-search abandons the search without issuing any strobe.
- Strobes are combinational from state plus inputs. At most one row strobe and one col strobe per cycle. Counters apply them on the next edge.
- States and transitions:
  - IDLE: start -> INIT.
  - INIT: assert row_reset, col_reset -> CHECK.
  - CHECK, conflict=0: -> PLACE.
  - CHECK, conflict=1 and col_value!=N-1: assert col_up, stay in CHECK.
  - CHECK, conflict=1 and col_value=N-1: -> BACKTRACK.
  - PLACE: assert stack_we. If row_value=N-1 -> SOLVED. Otherwise assert row_up and col_reset -> CHECK.
  - BACKTRACK: if row_zero -> FAIL. Otherwise assert row_down -> POP.
  - POP: stack_col is stack[row-1] after the decrement. If stack_col=N-1 -> BACKTRACK. Otherwise col_load with col_data=stack_col+1 -> CHECK.
  - SOLVED: start -> INIT (takes priority over next). If next and col_value!=N-1: assert col_up -> CHECK. If next and col_value=N-1: -> BACKTRACK.
  - FAIL: start -> INIT.
- col_data is 0 outside POP.
- col_data is computed modulo 2^W; the POP guard guarantees no wrap.
- busy = 1 in INIT, CHECK, PLACE, BACKTRACK, POP.
- done pulses for exactly one cycle on each entry into SOLVED or FAIL. It is registered and high in the first cycle of the new state.
- found is set on entering SOLVED and cleared on leaving SOLVED or on reset.
- no_solution is set on entering FAIL and cleared on leaving FAIL or on reset.
- start while busy is ignored. next outside SOLVED is ignored.
- In SOLVED, stack[0..N-1] holds the solution columns and the counters hold row=N-1, col=stack[N-1].

Test Plan:
1. N=8, start pulse -> found=1 with stack={0,4,7,5,2,6,1,3}. Exactly one done pulse. busy low in SOLVED.
2. N=8, start, then next pulsed on every SOLVED -> exactly 92 found events, then no_solution=1. The last solution is {7,3,0,2,5,1,6,4}.
3. N=4 -> solution {1,3,0,2}. After next -> {2,0,3,1}. After next -> no_solution=1, found=0.
4. N=1 (W=1), start sampled at edge e0 -> INIT, CHECK, PLACE. SOLVED is entered at e3 with stack={0}. done is high for the single cycle after e3.
5. N=3, W=2 -> FAIL reached with no_solution=1 and no SOLVED visits. A second start re-runs the search to FAIL again.
6. Reset asserted while in CHECK mid-search -> next cycle in IDLE with all outputs 0. A start pulse during busy -> no restart; the search path is unchanged.
